// File: rtl/cpu_control_unit_if.sv
// cpu_control_unit_if: control-unit bus to instruction memory, data memory and datapath
interface cpu_control_unit_if #(
  parameter int BUS_SIZE      = 16,
  parameter int ADDRESS_WIDTH = 4,
  parameter int FS_WIDTH      = 3
);
  logic                     instr_req;
  logic [BUS_SIZE-1:0]      instr_addr;
  logic                     instr_ready;
  logic [BUS_SIZE-1:0]      instr_data;
  logic                     mem_read;
  logic                     mem_write;
  logic                     mem_ready;
  logic [BUS_SIZE-1:0]      Dout;
  logic [ADDRESS_WIDTH-1:0] DA;
  logic [ADDRESS_WIDTH-1:0] AA;
  logic [ADDRESS_WIDTH-1:0] BA;
  logic [FS_WIDTH-1:0]      FS;
  logic                     MB;
  logic [1:0]               resultSource;
  logic                     RW;
  logic [BUS_SIZE-1:0]      PC;
  logic                     halted;
  modport master (
    output instr_req, instr_addr, mem_read, mem_write, DA, AA, BA, FS, MB, resultSource, RW, PC, halted,
    input  instr_ready, instr_data, mem_ready, Dout
  );
  modport slave (
    input  instr_req, instr_addr, mem_read, mem_write, DA, AA, BA, FS, MB, resultSource, RW, PC, halted,
    output instr_ready, instr_data, mem_ready, Dout
  );
endinterface

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle fetch/decode/execute sequencer driving cpuDatapath
module cpu_control_unit #(
  parameter int                  BUS_SIZE      = 16,
  parameter int                  ADDRESS_WIDTH = 4,
  parameter int                  FS_WIDTH      = 3,
  parameter logic [BUS_SIZE-1:0] RESET_PC      = '0
) (
  input logic               clk,
  input logic               reset,
  cpu_control_unit_if.master bus
);
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, HALT} state_e;
  state_e              state_q;
  logic [BUS_SIZE-1:0] pc_q;
  logic [BUS_SIZE-1:0] ir_q;
  logic [BUS_SIZE-1:0] off;
  logic [BUS_SIZE-1:0] pc_inc;
  logic [3:0]          op;
  logic                take;
  logic                writes;
  assign op     = ir_q[15:12];
  assign off    = {{(BUS_SIZE-8){ir_q[7]}}, ir_q[7:0]};
  assign pc_inc = pc_q + BUS_SIZE'(1);
  assign take   = (op == 4'hC && bus.Dout == '0) || (op == 4'hD && bus.Dout != '0);
  assign writes = op <= 4'h9 || op == 4'hE;
  assign bus.instr_req    = state_q == FETCH;
  assign bus.instr_addr   = pc_q;
  assign bus.mem_read     = state_q == MEM && op == 4'hA;
  assign bus.mem_write    = state_q == MEM && op == 4'hB;
  assign bus.halted       = state_q == HALT;
  assign bus.RW           = (state_q == EXECUTE && writes) || (bus.mem_read && bus.mem_ready);
  assign bus.DA           = ir_q[11:8];
  assign bus.AA           = ir_q[7:4];
  assign bus.BA           = ir_q[3:0];
  assign bus.FS           = op[3] ? '0 : FS_WIDTH'(op[2:0]);
  assign bus.MB           = op == 4'h8;
  assign bus.resultSource = op == 4'h9 ? 2'd3 : op == 4'hA ? 2'd2 : op == 4'hE ? 2'd1 : 2'd0;
  assign bus.PC           = pc_inc;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      case (state_q)
        FETCH: if (bus.instr_ready) begin
          ir_q    <= bus.instr_data;
          state_q <= DECODE;
        end
        DECODE: state_q <= EXECUTE;
        EXECUTE: begin
          state_q <= op == 4'hF ? HALT : (op == 4'hA || op == 4'hB) ? MEM : FETCH;
          if (op != 4'hA && op != 4'hB && op != 4'hF) pc_q <= (op == 4'hE || take) ? pc_q + off : pc_inc;
        end
        MEM: if (bus.mem_ready) begin
          pc_q    <= pc_inc;
          state_q <= FETCH;
        end
        HALT: state_q <= HALT;
        default: state_q <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: table-driven instruction stream with a register-write scoreboard
module tb_cpu_control_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  cpu_control_unit_if bus ();
  cpu_control_unit dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [3:0]  da, aa, ba;
    logic [1:0]  rs;
    logic [2:0]  fs;
    logic        mb, alu;
    logic [15:0] link;
  } wr_t;
  typedef struct {
    logic [15:0] ins, dout;
    int          iw, mw;
    logic [15:0] nxt;
  } vec_t;
  wr_t         wq[$];
  wr_t         w_m;
  vec_t        v[20];
  vec_t        h;
  int          tests = 0;
  int          fails = 0;
  logic [15:0] pc_m;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    #2;
    if (bus.RW === 1'b1) begin
      if (wq.size() == 0) chk("rw_unexpected", bus.RW, 0);
      else begin
        w_m = wq.pop_front();
        chk("rw_da", bus.DA, w_m.da);
        chk("rw_aa", bus.AA, w_m.aa);
        chk("rw_ba", bus.BA, w_m.ba);
        chk("rw_src", bus.resultSource, w_m.rs);
        chk("rw_link", bus.PC, w_m.link);
        if (w_m.alu) begin
          chk("rw_fs", bus.FS, w_m.fs);
          chk("rw_mb", bus.MB, w_m.mb);
        end
      end
    end
  end
  task automatic run(input vec_t t);
    int n, rd, wr;
    logic [3:0] op;
    op = t.ins[15:12];
    chk("fetch_req", bus.instr_req, 1);
    chk("fetch_addr", bus.instr_addr, pc_m);
    bus.Dout = t.dout;
    bus.instr_data = 16'hF000;
    repeat (t.iw) @(negedge clk);
    if (t.iw > 0) chk("fetch_hold", {bus.instr_req, bus.instr_addr}, {1'b1, pc_m});
    if (op <= 4'h9 || op == 4'hA || op == 4'hE)
      wq.push_back('{t.ins[11:8], t.ins[7:4], t.ins[3:0],
                     op == 4'h9 ? 2'd3 : op == 4'hA ? 2'd2 : op == 4'hE ? 2'd1 : 2'd0,
                     op[3] ? 3'd0 : op[2:0], op == 4'h8, op <= 4'h8, pc_m + 16'd1});
    bus.instr_data = t.ins;
    bus.instr_ready = 1'b1;
    n = 0;
    rd = 0;
    wr = 0;
    do begin
      @(negedge clk);
      bus.instr_ready = 1'b0;
      n++;
      rd += int'(bus.mem_read);
      wr += int'(bus.mem_write);
      bus.mem_ready = (bus.mem_read || bus.mem_write) && (rd + wr == t.mw + 1);
    end while (!bus.instr_req && n < 30);
    chk("latency", n, (op == 4'hA || op == 4'hB) ? 4 + t.mw : 3);
    chk("mem_read_cycles", rd, op == 4'hA ? t.mw + 1 : 0);
    chk("mem_write_cycles", wr, op == 4'hB ? t.mw + 1 : 0);
    pc_m = t.nxt;
  endtask
  initial begin
    v[0]  = '{16'h3120, 16'h0000, 0, 0, 16'h0001};
    v[1]  = '{16'h94F0, 16'h0000, 0, 0, 16'h0002};
    v[2]  = '{16'h8415, 16'h0000, 0, 0, 16'h0003};
    v[3]  = '{16'h5A7C, 16'h0000, 2, 0, 16'h0004};
    v[4]  = '{16'hC00C, 16'h0000, 0, 0, 16'h0010};
    v[5]  = '{16'hC2FE, 16'h0000, 0, 0, 16'h000E};
    v[6]  = '{16'hC002, 16'h0000, 0, 0, 16'h0010};
    v[7]  = '{16'hC2FE, 16'h0001, 0, 0, 16'h0011};
    v[8]  = '{16'hC0FF, 16'h0000, 0, 0, 16'h0010};
    v[9]  = '{16'hD205, 16'h8000, 0, 0, 16'h0015};
    v[10] = '{16'hD205, 16'h0000, 0, 0, 16'h0016};
    v[11] = '{16'hC000, 16'h0000, 0, 0, 16'h0016};
    v[12] = '{16'hA530, 16'h0000, 0, 3, 16'h0017};
    v[13] = '{16'hB530, 16'h0000, 0, 2, 16'h0018};
    v[14] = '{16'hA530, 16'h0000, 1, 0, 16'h0019};
    v[15] = '{16'hE0E6, 16'h0000, 0, 0, 16'hFFFF};
    v[16] = '{16'hE701, 16'h0000, 0, 0, 16'h0000};
    v[17] = '{16'hE0FF, 16'h0000, 0, 0, 16'hFFFF};
    v[18] = '{16'h1000, 16'h0000, 0, 0, 16'h0000};
    v[19] = '{16'h7ABC, 16'h0000, 1, 0, 16'h0001};
    bus.instr_ready = 1'b0;
    bus.instr_data = 16'h0000;
    bus.mem_ready = 1'b0;
    bus.Dout = 16'h0000;
    reset = 1'b1;
    pc_m = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_strobes", {bus.RW, bus.mem_read, bus.mem_write, bus.halted}, 4'b0000);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) run(v[i]);
    chk("mid_addr", bus.instr_addr, pc_m);
    bus.instr_data = 16'hA530;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_mem_w1", bus.mem_read, 1);
    @(negedge clk);
    chk("mid_mem_w2", bus.mem_read, 1);
    reset = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b1;
    #1;
    chk("abort_mem_read", bus.mem_read, 0);
    chk("abort_rw", bus.RW, 0);
    reset = 1'b0;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    pc_m = 16'h0000;
    h = '{16'h2345, 16'h0000, 0, 0, 16'h0001};
    run(h);
    chk("halt_addr", bus.instr_addr, pc_m);
    bus.instr_data = 16'hF000;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    @(negedge clk);
    chk("halt_exec_halted", bus.halted, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.instr_ready = 1'b1;
      bus.mem_ready = 1'b1;
      chk("halted", bus.halted, 1);
      chk("halt_req", {bus.instr_req, bus.mem_read, bus.mem_write, bus.RW}, 4'b0000);
    end
    bus.instr_ready = 1'b0;
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("unhalt", bus.halted, 0);
    chk("unhalt_fetch", {bus.instr_req, bus.instr_addr}, {1'b1, 16'h0000});
    @(negedge clk);
    chk("wq_empty", wq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
